// File: rtl/ram_seq_master_if.sv
// User-side bus between the memory self-test sequencer and the SRAM controller:
// active-low enable, read/write strobes, address/write data, and the done/read-data return.
interface ram_seq_master_if;
   logic        ctl_en;
   logic        ctl_we;
   logic        ctl_re;
   logic [17:0] ctl_addr;
   logic [15:0] ctl_data;
   logic        ctl_done;
   logic [15:0] ctl_rdata;

   modport master (
      output ctl_en, ctl_we, ctl_re, ctl_addr, ctl_data,
      input  ctl_done, ctl_rdata
   );

   modport slave (
      input  ctl_en, ctl_we, ctl_re, ctl_addr, ctl_data,
      output ctl_done, ctl_rdata
   );
endinterface

// File: rtl/ram_seq_master.sv
// SRAM self-test sequencer: writes a seeded pattern to WORD_COUNT words, reads back and compares.
// Define RAM_SEQ_STOP_ON_ERR_EN to end the run at the first read-back mismatch.
module ram_seq_master #(
   parameter logic [17:0] BASE_ADDR   = 18'h0,
   parameter int unsigned WORD_COUNT  = 256,
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      seed,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic [15:0]      err_count,
   output logic [17:0]      err_addr,
   output logic [15:0]      err_data,
   ram_seq_master_if.master bus
);

   localparam logic [17:0]   LAST_IDX  = 18'(WORD_COUNT - 1);
   localparam int unsigned   HW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);
   localparam int unsigned   TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE,
      W_SETUP,
      W_STROBE,
      W_RELEASE,
      R_SETUP,
      R_STROBE,
      R_RELEASE,
      R_CHECK,
      FINISH
   } state_t;

   state_t        state;
   logic [15:0]   seed_q;
   logic [17:0]   idx;
   logic          acked;
   logic [HW-1:0] hcnt;
   logic [TW-1:0] tcnt;

   logic wait_hi;
   logic wait_lo;
   logic pending;
   logic expired;
   logic last_word;
   logic mismatch;
   logic stop_now;

   function automatic logic [15:0] pat(input logic [17:0] a, input logic [15:0] s);
      return a[15:0] ^ s ^ {a[17:16], 14'h0};
   endfunction

   // One shared timeout counter covers every wait on a ctl_done edge.
   always_comb begin
      wait_hi   = (state == W_STROBE || state == R_STROBE) && !acked;
      wait_lo   = (state == W_RELEASE || state == R_RELEASE);
      pending   = (wait_hi && !bus.ctl_done) || (wait_lo && bus.ctl_done);
      expired   = pending && (tcnt == TO_LAST);
      last_word = (idx == LAST_IDX);
      mismatch  = (bus.ctl_rdata != pat(bus.ctl_addr, seed_q));
`ifdef RAM_SEQ_STOP_ON_ERR_EN
      stop_now  = last_word || mismatch;
`else
      stop_now  = last_word;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         seed_q       <= '0;
         idx          <= '0;
         acked        <= 1'b0;
         hcnt         <= '0;
         tcnt         <= '0;
         busy         <= 1'b0;
         pass         <= 1'b0;
         fail         <= 1'b0;
         err_count    <= '0;
         err_addr     <= '0;
         err_data     <= '0;
         bus.ctl_en   <= 1'b1;
         bus.ctl_we   <= 1'b0;
         bus.ctl_re   <= 1'b0;
         bus.ctl_addr <= '0;
         bus.ctl_data <= '0;
      end else begin
         tcnt <= pending ? tcnt + TW'(1) : '0;
         if (expired) begin
            bus.ctl_we <= 1'b0;
            bus.ctl_re <= 1'b0;
            bus.ctl_en <= 1'b1;
            fail       <= 1'b1;
            if (err_count == '0) begin
               err_addr <= bus.ctl_addr;
               err_data <= '0;
            end
            state <= FINISH;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     seed_q       <= seed;
                     busy         <= 1'b1;
                     pass         <= 1'b0;
                     fail         <= 1'b0;
                     err_count    <= '0;
                     err_addr     <= '0;
                     err_data     <= '0;
                     idx          <= '0;
                     bus.ctl_addr <= BASE_ADDR;
                     bus.ctl_data <= pat(BASE_ADDR, seed);
                     bus.ctl_en   <= 1'b0;
                     state        <= W_SETUP;
                  end
               end
               W_SETUP: begin
                  bus.ctl_we <= 1'b1;
                  acked      <= 1'b0;
                  state      <= W_STROBE;
               end
               // Strobe stays up HOLD_CYCLES clocks after done is first seen.
               W_STROBE, R_STROBE: begin
                  if (!acked) begin
                     if (bus.ctl_done) begin
                        acked <= 1'b1;
                        hcnt  <= HW'(1);
                     end
                  end else if (hcnt == HOLD_LAST) begin
                     bus.ctl_we <= 1'b0;
                     bus.ctl_re <= 1'b0;
                     state      <= (state == W_STROBE) ? W_RELEASE : R_RELEASE;
                  end else begin
                     hcnt <= hcnt + HW'(1);
                  end
               end
               W_RELEASE: begin
                  if (!bus.ctl_done) begin
                     if (last_word) begin
                        idx          <= '0;
                        bus.ctl_addr <= BASE_ADDR;
                        state        <= R_SETUP;
                     end else begin
                        idx          <= idx + 18'd1;
                        bus.ctl_addr <= bus.ctl_addr + 18'd1;
                        bus.ctl_data <= pat(bus.ctl_addr + 18'd1, seed_q);
                        state        <= W_SETUP;
                     end
                  end
               end
               R_SETUP: begin
                  bus.ctl_re <= 1'b1;
                  acked      <= 1'b0;
                  state      <= R_STROBE;
               end
               R_RELEASE: begin
                  if (!bus.ctl_done) state <= R_CHECK;
               end
               R_CHECK: begin
                  if (mismatch) begin
                     if (err_count == '0) begin
                        err_addr <= bus.ctl_addr;
                        err_data <= bus.ctl_rdata;
                     end
                     if (err_count != '1) err_count <= err_count + 16'd1;
                  end
                  if (stop_now) begin
                     bus.ctl_en <= 1'b1;
                     state      <= FINISH;
                  end else begin
                     idx          <= idx + 18'd1;
                     bus.ctl_addr <= bus.ctl_addr + 18'd1;
                     state        <= R_SETUP;
                  end
               end
               FINISH: begin
                  pass  <= (err_count == '0) && !fail;
                  fail  <= !((err_count == '0) && !fail);
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ram_seq_master.sv
// Self-checking bench for ram_seq_master: acknowledging SRAM responder models feed a write/read
// scoreboard; scenario tasks check latency, results, timeout, wrap, reset abort and ignored starts.
module tb_ram_seq_master;
   localparam int unsigned TO   = 16;
   localparam int unsigned ACK  = 3;
   localparam int unsigned HOLD = 4;
   // Per word: setup 1 + done seen 4 clocks after strobe + HOLD + done-low seen 2 clocks after release;
   // reads add the check clock; FINISH adds one.
   localparam int RUN_FULL = 4 * (1 + 4 + HOLD + 2) + 4 * (2 + 4 + HOLD + 2) + 1;
`ifdef RAM_SEQ_STOP_ON_ERR_EN
   localparam int RUN_CORRUPT = 4 * (1 + 4 + HOLD + 2) + 3 * (2 + 4 + HOLD + 2) + 1;
   localparam int NREAD_CORRUPT = 3;
`else
   localparam int RUN_CORRUPT = RUN_FULL;
   localparam int NREAD_CORRUPT = 4;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic [15:0] seed0 = '0, seed1 = '0;
   logic        busy0, pass0, fail0, busy1, pass1, fail1;
   logic [15:0] ec0, ed0, ec1, ed1;
   logic [17:0] ea0, ea1;

   int vectors = 0;
   int miscompares = 0;
   bit hang0 = 1'b0;
   bit corrupt0 = 1'b0;

   logic [33:0] wq0[$];
   logic [33:0] wq1[$];
   logic [17:0] rq0[$];
   logic [17:0] rq1[$];
   logic [15:0] mem0[logic [17:0]];
   logic [15:0] mem1[logic [17:0]];
   int unsigned dcnt0, dcnt1;

   ram_seq_master_if bus0();
   ram_seq_master_if bus1();

   ram_seq_master #(.BASE_ADDR(18'h0), .WORD_COUNT(4), .HOLD_CYCLES(HOLD), .TIMEOUT(TO)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .seed(seed0), .busy(busy0), .pass(pass0),
      .fail(fail0), .err_count(ec0), .err_addr(ea0), .err_data(ed0), .bus(bus0)
   );

   ram_seq_master #(.BASE_ADDR(18'h3FFFE), .WORD_COUNT(4), .HOLD_CYCLES(HOLD), .TIMEOUT(TO)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .seed(seed1), .busy(busy1), .pass(pass1),
      .fail(fail1), .err_count(ec1), .err_addr(ea1), .err_data(ed1), .bus(bus1)
   );

   function automatic logic [15:0] pat(input logic [17:0] a, input logic [15:0] s);
      return a[15:0] ^ s ^ {a[17:16], 14'h0};
   endfunction

   // Responder for dut0: acks ACK clocks after a strobe, drops done once the strobe drops.
   always @(posedge clk or negedge rst) begin : resp0
      logic [33:0] e;
      if (!rst) begin
         bus0.ctl_done  <= 1'b0;
         bus0.ctl_rdata <= '0;
         dcnt0          <= 0;
      end else if (!bus0.ctl_done) begin
         if ((bus0.ctl_we || bus0.ctl_re) && !hang0) begin
            if (dcnt0 == ACK - 1) begin
               bus0.ctl_done <= 1'b1;
               dcnt0         <= 0;
               vectors++;
               if (bus0.ctl_we) begin
                  mem0[bus0.ctl_addr] = bus0.ctl_data;
                  if (wq0.size() == 0) begin
                     miscompares++;
                     $display("FAIL wr0_unexpected: got %h/%h, expected none", bus0.ctl_addr, bus0.ctl_data);
                  end else begin
                     e = wq0.pop_front();
                     if ({bus0.ctl_addr, bus0.ctl_data} !== e) begin
                        miscompares++;
                        $display("FAIL wr0: got %h/%h, expected %h/%h", bus0.ctl_addr, bus0.ctl_data, e[33:16], e[15:0]);
                     end
                  end
               end else begin
                  bus0.ctl_rdata <= (corrupt0 && bus0.ctl_addr == 18'd2) ? 16'h0000 : mem0[bus0.ctl_addr];
                  if (rq0.size() == 0) begin
                     miscompares++;
                     $display("FAIL rd0_unexpected: got %h, expected none", bus0.ctl_addr);
                  end else begin
                     e[17:0] = rq0.pop_front();
                     if (bus0.ctl_addr !== e[17:0]) begin
                        miscompares++;
                        $display("FAIL rd0_addr: got %h, expected %h", bus0.ctl_addr, e[17:0]);
                     end
                  end
               end
            end else begin
               dcnt0 <= dcnt0 + 1;
            end
         end else begin
            dcnt0 <= 0;
         end
      end else if (!bus0.ctl_we && !bus0.ctl_re) begin
         bus0.ctl_done <= 1'b0;
      end
   end

   always @(posedge clk or negedge rst) begin : resp1
      logic [33:0] e;
      if (!rst) begin
         bus1.ctl_done  <= 1'b0;
         bus1.ctl_rdata <= '0;
         dcnt1          <= 0;
      end else if (!bus1.ctl_done) begin
         if (bus1.ctl_we || bus1.ctl_re) begin
            if (dcnt1 == ACK - 1) begin
               bus1.ctl_done <= 1'b1;
               dcnt1         <= 0;
               vectors++;
               if (bus1.ctl_we) begin
                  mem1[bus1.ctl_addr] = bus1.ctl_data;
                  e = (wq1.size() != 0) ? wq1.pop_front() : 34'h3FFFFFFFF;
                  if ({bus1.ctl_addr, bus1.ctl_data} !== e) begin
                     miscompares++;
                     $display("FAIL wr1: got %h/%h, expected %h/%h", bus1.ctl_addr, bus1.ctl_data, e[33:16], e[15:0]);
                  end
               end else begin
                  bus1.ctl_rdata <= mem1[bus1.ctl_addr];
                  e[17:0] = (rq1.size() != 0) ? rq1.pop_front() : 18'h3FFFF;
                  if (bus1.ctl_addr !== e[17:0]) begin
                     miscompares++;
                     $display("FAIL rd1_addr: got %h, expected %h", bus1.ctl_addr, e[17:0]);
                  end
               end
            end else begin
               dcnt1 <= dcnt1 + 1;
            end
         end else begin
            dcnt1 <= 0;
         end
      end else if (!bus1.ctl_we && !bus1.ctl_re) begin
         bus1.ctl_done <= 1'b0;
      end
   end

   // Bus rules on dut0: strobes exclusive; address/data frozen while a strobe is up.
   logic [17:0] pa0 = '0;
   logic [15:0] pd0 = '0;
   always @(negedge clk) begin
      if (bus0.ctl_we && bus0.ctl_re) begin
         vectors++;
         miscompares++;
         $display("FAIL strobe_excl: got we=1 re=1, expected not both");
      end
      if ((bus0.ctl_we || bus0.ctl_re) && (bus0.ctl_addr !== pa0 || bus0.ctl_data !== pd0)) begin
         vectors++;
         miscompares++;
         $display("FAIL bus_stable: got %h/%h, expected %h/%h", bus0.ctl_addr, bus0.ctl_data, pa0, pd0);
      end
      pa0 = bus0.ctl_addr;
      pd0 = bus0.ctl_data;
   end

   task automatic push_run0(input logic [15:0] s, input int nreads);
      for (int i = 0; i < 4; i++) wq0.push_back({18'(i), pat(18'(i), s)});
      for (int i = 0; i < nreads; i++) rq0.push_back(18'(i));
   endtask

   task automatic start0_pulse(input logic [15:0] s);
      @(negedge clk);
      seed0  = s;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic wait_idle0(input int n0, output int n);
      n = n0;
      while (busy0 && n < 400) begin
         n++;
         @(negedge clk);
      end
      if (busy0) begin
         vectors++;
         miscompares++;
         $display("FAIL idle0_bound: got busy=1 after %0d clocks, expected 0", n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy0, pass0, fail0, ec0, ea0, ed0} !== 53'h0) begin
         miscompares++;
         $display("FAIL reset_status: got %b%b%b %h %h %h, expected 000 0 0 0", busy0, pass0, fail0, ec0, ea0, ed0);
      end
      vectors++;
      if ({bus0.ctl_en, bus0.ctl_we, bus0.ctl_re, bus0.ctl_addr, bus0.ctl_data} !== {3'b100, 34'h0}) begin
         miscompares++;
         $display("FAIL reset_bus: got en=%b we=%b re=%b %h/%h, expected en=1 we=0 re=0 0/0",
                  bus0.ctl_en, bus0.ctl_we, bus0.ctl_re, bus0.ctl_addr, bus0.ctl_data);
      end
      vectors++;
      if ({busy1, bus1.ctl_en, bus1.ctl_addr} !== {2'b01, 18'h0}) begin
         miscompares++;
         $display("FAIL reset_dut1: got busy=%b en=%b addr=%h, expected 0 1 0", busy1, bus1.ctl_en, bus1.ctl_addr);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int n;
      wq0.push_back({18'd0, 16'hA5A5});
      wq0.push_back({18'd1, 16'hA5A4});
      wq0.push_back({18'd2, 16'hA5A7});
      wq0.push_back({18'd3, 16'hA5A6});
      for (int i = 0; i < 4; i++) rq0.push_back(18'(i));
      start0_pulse(16'hA5A5);
      vectors++;
      if ({busy0, bus0.ctl_en, bus0.ctl_we} !== 3'b100) begin
         miscompares++;
         $display("FAIL start_latency: got busy=%b en=%b we=%b, expected 1 0 0", busy0, bus0.ctl_en, bus0.ctl_we);
      end
      @(negedge clk);
      vectors++;
      if (bus0.ctl_we !== 1'b1) begin
         miscompares++;
         $display("FAIL strobe_rise: got we=%b, expected 1", bus0.ctl_we);
      end
      wait_idle0(1, n);
      vectors++;
      if (n !== RUN_FULL) begin
         miscompares++;
         $display("FAIL basic_length: got %0d, expected %0d", n, RUN_FULL);
      end
      vectors++;
      if ({pass0, fail0, ec0, bus0.ctl_en} !== {2'b10, 16'h0, 1'b1}) begin
         miscompares++;
         $display("FAIL basic_result: got pass=%b fail=%b cnt=%h en=%b, expected 1 0 0 1", pass0, fail0, ec0, bus0.ctl_en);
      end
      vectors++;
      if (wq0.size() != 0 || rq0.size() != 0) begin
         miscompares++;
         $display("FAIL basic_drain: got %0d/%0d pending, expected 0/0", wq0.size(), rq0.size());
      end
   endtask

   task automatic test_corrupt();
      int n;
      push_run0(16'hA5A5, NREAD_CORRUPT);
      corrupt0 = 1'b1;
      start0_pulse(16'hA5A5);
      wait_idle0(0, n);
      corrupt0 = 1'b0;
      vectors++;
      if (n !== RUN_CORRUPT) begin
         miscompares++;
         $display("FAIL corrupt_length: got %0d, expected %0d", n, RUN_CORRUPT);
      end
      vectors++;
      if ({pass0, fail0, ec0, ea0, ed0} !== {2'b01, 16'd1, 18'd2, 16'h0}) begin
         miscompares++;
         $display("FAIL corrupt_result: got pass=%b fail=%b cnt=%h addr=%h data=%h, expected 0 1 1 2 0",
                  pass0, fail0, ec0, ea0, ed0);
      end
      vectors++;
      if (wq0.size() != 0 || rq0.size() != 0) begin
         miscompares++;
         $display("FAIL corrupt_drain: got %0d/%0d pending, expected 0/0", wq0.size(), rq0.size());
      end
   endtask

   task automatic test_timeout();
      int n;
      hang0 = 1'b1;
      start0_pulse(16'h0F0F);
      repeat (TO) @(negedge clk);
      vectors++;
      if ({fail0, bus0.ctl_we} !== 2'b01) begin
         miscompares++;
         $display("FAIL timeout_early: got fail=%b we=%b, expected 0 1", fail0, bus0.ctl_we);
      end
      @(negedge clk);
      vectors++;
      if ({fail0, bus0.ctl_we, bus0.ctl_re, bus0.ctl_en} !== 4'b1001) begin
         miscompares++;
         $display("FAIL timeout_edge: got fail=%b we=%b re=%b en=%b, expected 1 0 0 1",
                  fail0, bus0.ctl_we, bus0.ctl_re, bus0.ctl_en);
      end
      wait_idle0(TO + 1, n);
      hang0 = 1'b0;
      vectors++;
      if (n !== TO + 2) begin
         miscompares++;
         $display("FAIL timeout_length: got %0d, expected %0d", n, TO + 2);
      end
      vectors++;
      if ({pass0, fail0, ec0, ea0, ed0} !== {2'b01, 50'h0}) begin
         miscompares++;
         $display("FAIL timeout_result: got pass=%b fail=%b cnt=%h addr=%h data=%h, expected 0 1 0 0 0",
                  pass0, fail0, ec0, ea0, ed0);
      end
   endtask

   task automatic test_wrap();
      int n;
      logic [17:0] addrs[4];
      addrs[0] = 18'h3FFFE;
      addrs[1] = 18'h3FFFF;
      addrs[2] = 18'h00000;
      addrs[3] = 18'h00001;
      for (int i = 0; i < 4; i++) wq1.push_back({addrs[i], pat(addrs[i], 16'h1234)});
      for (int i = 0; i < 4; i++) rq1.push_back(addrs[i]);
      @(negedge clk);
      seed1  = 16'h1234;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (busy1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      vectors++;
      if (n !== RUN_FULL) begin
         miscompares++;
         $display("FAIL wrap_length: got %0d, expected %0d", n, RUN_FULL);
      end
      vectors++;
      if ({pass1, fail1, ec1} !== {2'b10, 16'h0}) begin
         miscompares++;
         $display("FAIL wrap_result: got pass=%b fail=%b cnt=%h, expected 1 0 0", pass1, fail1, ec1);
      end
      vectors++;
      if (wq1.size() != 0 || rq1.size() != 0) begin
         miscompares++;
         $display("FAIL wrap_drain: got %0d/%0d pending, expected 0/0", wq1.size(), rq1.size());
      end
   endtask

   task automatic test_busy_ignored();
      int n;
      push_run0(16'h3C3C, 4);
      start0_pulse(16'h3C3C);
      n = 0;
      while (busy0 && n < 400) begin
         n++;
         start0 = (n == 5 || n == 40 || n == 70 || n == RUN_FULL);
         seed0  = 16'hFFFF;
         @(negedge clk);
      end
      start0 = 1'b0;
      vectors++;
      if (n !== RUN_FULL) begin
         miscompares++;
         $display("FAIL ignore_length: got %0d, expected %0d", n, RUN_FULL);
      end
      vectors++;
      if ({pass0, fail0, ec0} !== {2'b10, 16'h0}) begin
         miscompares++;
         $display("FAIL ignore_result: got pass=%b fail=%b cnt=%h, expected 1 0 0", pass0, fail0, ec0);
      end
      @(negedge clk);
      vectors++;
      if (busy0 !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore_restart: got busy=%b, expected 0", busy0);
      end
      vectors++;
      if (wq0.size() != 0 || rq0.size() != 0) begin
         miscompares++;
         $display("FAIL ignore_drain: got %0d/%0d pending, expected 0/0", wq0.size(), rq0.size());
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int w;
      push_run0(16'h1111, 4);
      start0_pulse(16'h1111);
      w = 0;
      while (!bus0.ctl_we && w < 20) begin
         w++;
         @(negedge clk);
      end
      vectors++;
      if (bus0.ctl_we !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_strobe: got we=%b, expected 1", bus0.ctl_we);
      end
      #1 rst = 1'b0;
      #1;
      vectors++;
      if ({bus0.ctl_en, bus0.ctl_we, bus0.ctl_re, busy0, pass0, fail0, ec0, bus0.ctl_addr} !== {6'b100000, 34'h0}) begin
         miscompares++;
         $display("FAIL midrst_abort: got en=%b we=%b re=%b busy=%b pass=%b fail=%b cnt=%h addr=%h, expected 1 0 0 0 0 0 0 0",
                  bus0.ctl_en, bus0.ctl_we, bus0.ctl_re, busy0, pass0, fail0, ec0, bus0.ctl_addr);
      end
      wq0.delete();
      rq0.delete();
      @(negedge clk);
      rst = 1'b1;
      push_run0(16'h2222, 4);
      start0_pulse(16'h2222);
      wait_idle0(0, n);
      vectors++;
      if (n !== RUN_FULL || {pass0, fail0, ec0} !== {2'b10, 16'h0}) begin
         miscompares++;
         $display("FAIL midrst_rerun: got len=%0d pass=%b fail=%b cnt=%h, expected %0d 1 0 0",
                  n, pass0, fail0, ec0, RUN_FULL);
      end
      vectors++;
      if (wq0.size() != 0 || rq0.size() != 0) begin
         miscompares++;
         $display("FAIL midrst_drain: got %0d/%0d pending, expected 0/0", wq0.size(), rq0.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corrupt();
      test_timeout();
      test_wrap();
      test_busy_ignored();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      miscompares++;
      $display("FAIL watchdog: got no completion by 200000, expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ram_seq_master.md
# ram_seq_master

Sequencing initiator for the user side of the SRAM controller: on `start` it writes a generated 16-bit pattern to `WORD_COUNT` consecutive SRAM words, reads them back and compares. It drives the controller's active-low chip enable, its read/write strobes, address and write data, and paces every access on the controller's `done` handshake. It sits between the UART command layer and the RAM controller and serves as the board's built-in memory self-test.

## Interface
- `BASE_ADDR`, 18'h0 — first word address.
- `WORD_COUNT`, 256 — words tested, 1..2^18.
- `HOLD_CYCLES`, 4 — clocks a strobe is held after `ctl_done` rises, ≥1.
- `TIMEOUT`, 1024 — clocks allowed for each `ctl_done` edge.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle pulse; begins a test run when idle.
- `seed` in 16 — pattern seed, sampled on accepted `start`.
- `busy` out 1 — run in progress.
- `pass` out 1 — last run completed with no errors.
- `fail` out 1 — last run saw a mismatch or timeout.
- `err_count` out 16 — mismatches counted in this run; saturates at 16'hFFFF.
- `err_addr` out 18 — address of the first error.
- `err_data` out 16 — data read at the first error (16'h0 on timeout).
- `ctl_en` out 1 — controller enable, active-low.
- `ctl_we` out 1 — write strobe, active-high.
- `ctl_re` out 1 — read strobe, active-high.
- `ctl_addr` out 18 — word address.
- `ctl_data` out 16 — write data.
- `ctl_done` in 1 — controller access acknowledge.
- `ctl_rdata` in 16 — controller read data, valid after `ctl_done` falls on a read.

## Operation
- Pattern: `pat(a) = a[15:0] ^ seed_q ^ {a[17:16], 14'h0}`.
- Addresses: `BASE_ADDR + i` for i = 0..WORD_COUNT-1, modulo 2^18 (wraps 3FFFF→00000).
- States: IDLE, W_SETUP, W_STROBE, W_RELEASE, R_SETUP, R_STROBE, R_RELEASE, R_CHECK, FINISH.
- IDLE: `ctl_en`=1, strobes=0. An accepted `start` latches `seed`, clears `err_count`/`pass`/`fail`/`err_*`, sets `busy`, and goes to W_SETUP.
- W_SETUP (1 clk): `ctl_en`=0, addr and data driven.
- W_STROBE: `ctl_we`=1. Wait for `ctl_done`=1, then hold `HOLD_CYCLES`.
- W_RELEASE: `ctl_we`=0. Wait for `ctl_done`=0. Then go to the next address, or to R_SETUP at i=0 after the last word.
- The read phase mirrors the write phase using `ctl_re`. R_RELEASE waits for `ctl_done`=0, then R_CHECK captures `ctl_rdata` and compares it with `pat(addr)`.
- Mismatch: increment `err_count`. On the first error, record `err_addr` and `err_data`.
- FINISH (1 clk): `pass` = (`err_count`==0), `fail` = !pass, `busy`=0, return to IDLE. `pass`/`fail`/`err_*` hold until the next accepted `start`.
- Timeout: any wait on `ctl_done` exceeding `TIMEOUT` clocks → set `fail`, record `err_addr`, set `err_data`=0, drop strobes, go to FINISH. A timeout sets `fail` even when `err_count`=0.
- `start` while `busy` is ignored.
- `ctl_we` and `ctl_re` are never both 1.
- `ctl_addr`/`ctl_data` change only while both strobes are 0.

## Timing
- Reset (async assert, sync release): state IDLE, `ctl_en`=1, `ctl_we`=`ctl_re`=0, `ctl_addr`=0, `ctl_data`=0, `busy`=`pass`=`fail`=0, `err_count`=0, `err_addr`=0, `err_data`=0.
- Reset mid-run aborts at once with all of the above. No partial result is kept.
- `start` → `busy` high next clock; strobe rises 2 clocks after `start`.
- Per word, with `ctl_done` rising D and falling F clocks after strobe edges: write = 1 + D + HOLD_CYCLES + F; read = write + 1.
- All outputs are registered.

## Configuration
- `RAM_SEQ_STOP_ON_ERR_EN` defined: the first mismatch goes directly to FINISH after recording `err_addr`/`err_data`, leaving `err_count`=1.
- Undefined: the full range is always read back and every mismatch is counted.

## Test plan
- Responder model acks in 3 clocks, `BASE_ADDR`=0, `WORD_COUNT`=4, `seed`=16'hA5A5 → writes A5A5, A5A4, A5A7, A5A6; read back matches; `pass`=1, `err_count`=0.
- Model corrupts the read at address 2 to 16'h0000 → `fail`=1, `err_addr`=2, `err_data`=0. Without the macro, `err_count`=1 after all 4 reads; with it, the run stops after the read at address 2.
- Model never raises `ctl_done` → `fail`=1 after 1 + `TIMEOUT` clocks, `err_data`=0, `ctl_we`=0.
- `BASE_ADDR`=18'h3FFFE, `WORD_COUNT`=4 → addresses 3FFFE, 3FFFF, 00000, 00001 are used.
- Assert `rst` during W_STROBE → `ctl_en`=1 and `ctl_we`=0 immediately. A new `start` after release runs normally.
- Pulse `start` while `busy` → no effect; run length and results are unchanged.
